// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared defaults and FSM encoding for the period meter
package period_meter_pkg;

    localparam int PM_WIDTH   = 32;
    localparam int PM_TIMEOUT = 2**20;

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2} pm_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ARM  = ARM;
    localparam logic [1:0] ST_MEAS = MEAS;

endpackage

// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - control, signal and measurement-result bundle of the period meter
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int WIDTH = PM_WIDTH
);
    logic             enable;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (
        output enable, sig_in,
        input  period, high_time, valid, locked, timeout
    );

    modport slave (
        input  enable, sig_in,
        output period, high_time, valid, locked, timeout
    );
endinterface

// File: rtl/period_meter_edge_sync.sv
// rtl/period_meter_edge_sync.sv - synchroniser plus one-cycle rise/fall detector
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);
    logic w_s;
    logic r_s_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_s = i_d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s_q <= 1'b0;
        end else begin
            r_s_q <= w_s;
        end
    end

    assign o_s    = w_s;
    assign o_rise = w_s & ~r_s_q;
    assign o_fall = ~w_s & r_s_q;
endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures clock cycles between rising edges of a signal and its high time
module period_meter
    import period_meter_pkg::*;
#(
    parameter int          WIDTH       = PM_WIDTH,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = PM_TIMEOUT
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    period_meter_if.slave  bus
);
    localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT);

    logic             w_s;
    logic             w_rise;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (bus.sig_in),
        .o_s       (w_s),
        .o_rise    (w_rise),
        .o_fall    ()
    );

    // The rise cycle itself counts as cycle 1 (and as high) of the new period.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!bus.enable) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_hcnt   <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_ARM;
                    ST_ARM: begin
                        if (w_rise) begin
                            r_cnt    <= WIDTH'(1);
                            r_hcnt   <= WIDTH'(1);
                            r_locked <= 1'b0;
                            r_state  <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hcnt;
                            r_valid     <= 1'b1;
                            r_locked    <= 1'b1;
                            r_timeout   <= 1'b0;
                            r_cnt       <= WIDTH'(1);
                            r_hcnt      <= WIDTH'(1);
                        end else if (r_cnt == TO_CNT) begin
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                            r_state   <= ST_ARM;
                        end else begin
                            r_cnt <= r_cnt + WIDTH'(1);
                            if (w_s) begin
                                r_hcnt <= r_hcnt + WIDTH'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high_time;
    assign bus.valid     = r_valid;
    assign bus.locked    = r_locked;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter
module tb_period_meter;
    localparam int W    = 16;
    localparam int SYNC = 2;
    localparam int TO   = 50;

    typedef struct {
        int period;
        int high;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   last_rise_cyc = 0;
    exp_t sb[$];

    period_meter_if #(.WIDTH(W)) m ();

    period_meter #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (resetn),
        .bus       (m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn === 1'b1 && m.valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid period=%0d high=%0d required=no valid", m.period, m.high_time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (m.period !== W'(e.period) || m.high_time !== W'(e.high)) begin
                    errors++;
                    $display("FAIL valid_data period=%0d high=%0d required period=%0d high=%0d",
                             m.period, m.high_time, e.period, e.high);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_valid_cyc !== e.gap) begin
                        errors++;
                        $display("FAIL valid_spacing got=%0d required=%0d", cyc - last_valid_cyc, e.gap);
                    end
                end
            end
            last_valid_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rearm();
        m.enable = 1'b0;
        m.sig_in = 1'b0;
        repeat (3) tick();
        m.enable = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drain(input string name);
        repeat (SYNC + 4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d required=0", name, sb.size());
        end
    endtask

    // armed=1: the meter is already measuring, so every rise closes a period.
    task automatic drive_wave(input int p, input int h, input int n, input bit armed);
        int nv = 0;
        for (int k = 0; k < n; k++) begin
            m.sig_in = 1'b1;
            last_rise_cyc = cyc;
            if (armed || k > 0) begin
                sb.push_back('{period: p, high: h, gap: (nv > 0) ? p : 0});
                nv++;
            end
            repeat (h) tick();
            m.sig_in = 1'b0;
            repeat (p - h) tick();
        end
    endtask

    task automatic check_outs(input string name, input int period, input int high,
                              input bit locked, input bit timeout);
        checks++;
        if (m.period !== W'(period) || m.high_time !== W'(high) ||
            m.locked !== locked || m.timeout !== timeout) begin
            errors++;
            $display("FAIL %s got p=%0d h=%0d lk=%0b to=%0b required p=%0d h=%0d lk=%0b to=%0b",
                     name, m.period, m.high_time, m.locked, m.timeout, period, high, locked, timeout);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        m.enable = 1'b1;
        m.sig_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m.sig_in = ~m.sig_in;
            tick();
            check_outs("reset_outputs", 0, 0, 1'b0, 1'b0);
            checks++;
            if (m.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid got=%0b required=0", m.valid);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        rearm();
        drive_wave(6, 2, 6, 1'b0);
        drain("basic");
        check_outs("basic_final", 6, 2, 1'b1, 1'b0);
    endtask

    task automatic test_divider();
        rearm();
        drive_wave(4, 2, 11, 1'b0);
        drain("divider");
        check_outs("divider_final", 4, 2, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int waited = 0;
        rearm();
        drive_wave(6, 3, 3, 1'b0);
        while (m.timeout !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        checks++;
        if (cyc - last_rise_cyc !== TO + SYNC + 1) begin
            errors++;
            $display("FAIL timeout_latency got=%0d required=%0d", cyc - last_rise_cyc, TO + SYNC + 1);
        end
        check_outs("timeout_hold", 6, 3, 1'b0, 1'b1);
        drive_wave(6, 3, 3, 1'b0);
        drain("timeout_restart");
        check_outs("timeout_cleared", 6, 3, 1'b1, 1'b0);
    endtask

    task automatic test_enable();
        rearm();
        drive_wave(6, 2, 3, 1'b0);
        drain("enable_pre");
        m.sig_in = 1'b1;
        tick();
        tick();
        m.enable = 1'b0;
        repeat (3) tick();
        m.sig_in = 1'b0;
        m.enable = 1'b1;
        repeat (4) tick();
        check_outs("enable_gap", 6, 2, 1'b0, 1'b0);
        drive_wave(5, 2, 1, 1'b0);
        check_outs("enable_first_rise", 6, 2, 1'b0, 1'b0);
        drive_wave(5, 2, 2, 1'b1);
        drain("enable_post");
        check_outs("enable_final", 5, 2, 1'b1, 1'b0);
    endtask

    task automatic test_toggle_reset();
        rearm();
        drive_wave(2, 1, 6, 1'b0);
        drain("toggle");
        check_outs("toggle_final", 2, 1, 1'b1, 1'b0);
        resetn = 1'b0;
        tick();
        check_outs("midmeas_reset", 0, 0, 1'b0, 1'b0);
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divider();
        test_timeout();
        test_enable();
        test_toggle_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
